// File: rtl/run_sequencer_pkg.sv
// run_seq_pkg: shared types and defaults for the 3BC run sequencer.
//   - state_e      : run controller state encoding (IDLE, ARM, RUN, DONE)
//   - DEF_PC_W     : default program counter width
//   - DEF_CYC_W    : default cycle counter width
//   - DEF_PROGn_BASE : first instruction address of each resident program
//   - NUM_PROGS    : number of resident programs
//   - next_prog()  : round-robin program index advance (0 -> 1 -> 2 -> 0)
package run_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEF_PC_W  = 11;
  localparam int DEF_CYC_W = 16;

  localparam logic [10:0] DEF_PROG0_BASE = 11'd0;
  localparam logic [10:0] DEF_PROG1_BASE = 11'd256;
  localparam logic [10:0] DEF_PROG2_BASE = 11'd512;

  localparam int          NUM_PROGS = 3;
  localparam logic [1:0]  LAST_PROG = 2'(NUM_PROGS - 1);

  function automatic logic [1:0] next_prog(input logic [1:0] cur);
    return (cur == LAST_PROG) ? 2'd0 : cur + 2'd1;
  endfunction

endpackage

// File: rtl/run_sequencer_if.sv
// run_sequencer_if: handshake/status bundle between the run sequencer and
// its environment (testbench Start pin, Ctrl halt flag, PC controls).
//   Start, HaltReq           : driven by the environment (master)
//   PcEn, PcLoad, PcLoadAddr : program counter controls (from sequencer)
//   ProgSel, Ack, Busy       : run status (from sequencer)
//   CycleCt, Timeout         : run statistics (from sequencer)
// Modports: master = environment side, slave = sequencer side.
interface run_sequencer_if
  import run_seq_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int CYC_W = DEF_CYC_W
);

  logic             Start;
  logic             HaltReq;
  logic             PcEn;
  logic             PcLoad;
  logic [PC_W-1:0]  PcLoadAddr;
  logic [1:0]       ProgSel;
  logic             Ack;
  logic             Busy;
  logic [CYC_W-1:0] CycleCt;
  logic             Timeout;

  modport master (
    output Start, HaltReq,
    input  PcEn, PcLoad, PcLoadAddr, ProgSel, Ack, Busy, CycleCt, Timeout
  );

  modport slave (
    input  Start, HaltReq,
    output PcEn, PcLoad, PcLoadAddr, ProgSel, Ack, Busy, CycleCt, Timeout
  );

endinterface

// File: rtl/run_sequencer_sat_counter.sv
// sat_counter: WIDTH-bit up counter with synchronous clear and enable that
// sticks at all-ones instead of wrapping.
//   Clk, Reset : clock and synchronous active-high reset
//   clr        : clear to zero (wins over en)
//   en         : count up by one
//   count      : current value
//   tc         : high while count equals TC_VALUE
module sat_counter #(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] TC_VALUE = '1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == TC_VALUE);

endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: Start/Ack run controller for the 3BC processor.
// Selects one of three resident programs, loads its base address into the
// PC while armed, gates PC advance while running and counts run cycles.
//   Clk, Reset : clock (posedge) and synchronous active-high reset
//   bus        : run_sequencer_if.slave (Start, HaltReq in; PcEn, PcLoad,
//                PcLoadAddr, ProgSel, Ack, Busy, CycleCt, Timeout out)
// Build option: define WATCHDOG_EN to end a run once CycleCt reaches
// WDOG_LIMIT and flag it on Timeout; otherwise Timeout is tied low.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int               PC_W       = DEF_PC_W,
  parameter int               CYC_W      = DEF_CYC_W,
  parameter logic [PC_W-1:0]  PROG0_BASE = PC_W'(DEF_PROG0_BASE),
  parameter logic [PC_W-1:0]  PROG1_BASE = PC_W'(DEF_PROG1_BASE),
  parameter logic [PC_W-1:0]  PROG2_BASE = PC_W'(DEF_PROG2_BASE),
  parameter logic [CYC_W-1:0] WDOG_LIMIT = '1
) (
  input logic             Clk,
  input logic             Reset,
  run_sequencer_if.slave  bus
);

  state_e      state_q, state_d;
  logic [1:0]  prog_sel_q, prog_sel_d;
  logic        ct_clr, ct_en;
  logic        wdog_tc;
  logic        wdog_exit;

`ifdef WATCHDOG_EN
  localparam logic WDOG_ON = 1'b1;
`else
  localparam logic WDOG_ON = 1'b0;
`endif

  // The terminal count fires one cycle before the limit so the run ends
  // with CycleCt landing exactly on WDOG_LIMIT.
  sat_counter #(
    .WIDTH    (CYC_W),
    .TC_VALUE (CYC_W'(WDOG_LIMIT - 1'b1))
  ) u_cycle_ct (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (ct_clr),
    .en    (ct_en),
    .count (bus.CycleCt),
    .tc    (wdog_tc)
  );

  // A real halt on the same cycle is reported as a normal finish.
  assign wdog_exit = WDOG_ON && wdog_tc && !bus.HaltReq;

  // Next-state logic: abort via Start beats halt, halt beats the watchdog.
  always_comb begin
    state_d    = state_q;
    prog_sel_d = prog_sel_q;
    ct_clr     = 1'b0;
    ct_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) state_d = ARM;
      end
      ARM: begin
        ct_clr = 1'b1;
        if (!bus.Start) state_d = RUN;
      end
      RUN: begin
        ct_en = 1'b1;
        if (bus.Start) begin
          state_d = ARM;
        end else if (bus.HaltReq || wdog_exit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.Start) begin
          state_d    = ARM;
          prog_sel_d = next_prog(prog_sel_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      prog_sel_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      prog_sel_q <= prog_sel_d;
    end
  end

`ifdef WATCHDOG_EN
  logic timeout_q, timeout_d;

  // Timeout is sticky from the watchdog exit until the next ARM.
  always_comb begin
    timeout_d = timeout_q;
    if (state_q == ARM) begin
      timeout_d = 1'b0;
    end else if ((state_q == RUN) && !bus.Start && wdog_exit) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign bus.Timeout = timeout_q;
`else
  assign bus.Timeout = 1'b0;
`endif

  // Base address is always presented so the PC can load in any state.
  always_comb begin
    case (prog_sel_q)
      2'd0:    bus.PcLoadAddr = PROG0_BASE;
      2'd1:    bus.PcLoadAddr = PROG1_BASE;
      2'd2:    bus.PcLoadAddr = PROG2_BASE;
      default: bus.PcLoadAddr = PROG0_BASE;
    endcase
  end

  // PcEn drops combinationally so the PC stays on the halt instruction.
  assign bus.PcEn    = (state_q == RUN) && !bus.HaltReq;
  assign bus.PcLoad  = (state_q == ARM);
  assign bus.Busy    = (state_q == ARM) || (state_q == RUN);
  assign bus.Ack     = (state_q == DONE);
  assign bus.ProgSel = prog_sel_q;

endmodule
